mii_rx_deframer: RTL and testbench

- Receive-side MII front end, directly downstream of the PHY pins (`phy_rxd`, `phy_rx_dv`, `phy_rx_er`) and upstream of the Ethernet MAC/UDP receive path in `fpga_core`.
- Strips the preamble and SFD, and assembles nibbles into bytes, low nibble first.
- Emits the frame as a byte stream without backpressure, tagging the last byte.
- Flags bad frames (CRC, `rx_er`, runt, odd nibble) on the last byte and keeps saturating good/bad frame counters.

---
 rtl/mii_rx_deframer.sv | 143 ++++++++++++++
 tb/tb_mii_rx_deframer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mii_rx_deframer.sv
// mii_rx_deframer: MII receive preamble/SFD stripper, nibble-to-byte packer with CRC-32 check and frame counters
module mii_rx_deframer #(
    parameter int MIN_PREAMBLE_NIBBLES = 4,
    parameter int MIN_FRAME_BYTES      = 64,
    parameter int CNT_WIDTH            = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           mii_rxd,
    input  logic                 mii_rx_dv,
    input  logic                 mii_rx_er,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    output logic [CNT_WIDTH-1:0] frame_good_cnt,
    output logic [CNT_WIDTH-1:0] frame_bad_cnt
);
    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;
    state_t      state, state_nx;
    logic [3:0]  pcnt;
    logic [3:0]  lo;
    logic        have_lo;
    logic [7:0]  cur;
    logic        cur_v;
    logic [7:0]  hold;
    logic        hold_v;
    logic        bad;
    logic        fin;
    logic        fin_bad;
    logic [31:0] crc;
    logic [15:0] byte_cnt;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
        return r;
    endfunction

    assign fin_bad = !hold_v || bad || crc != 32'hDEBB20E3 || byte_cnt < 16'(MIN_FRAME_BYTES);

    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;

    // next-state: framing decisions from dv and nibble values only
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (mii_rx_dv) state_nx = (mii_rxd == 4'h5) ? PREAMBLE : DROP;
            PREAMBLE: if (!mii_rx_dv) state_nx = IDLE;
                      else if (mii_rxd == 4'h5) state_nx = PREAMBLE;
                      else if (mii_rxd == 4'hD && int'(pcnt) >= MIN_PREAMBLE_NIBBLES) state_nx = DATA;
                      else state_nx = DROP;
            DATA:     if (!mii_rx_dv) state_nx = IDLE;
            DROP:     if (!mii_rx_dv) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // datapath: nibble pairing, one-byte holdback, CRC, end-of-frame beat and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt           <= '0;
            lo             <= '0;
            have_lo        <= 1'b0;
            cur            <= '0;
            cur_v          <= 1'b0;
            hold           <= '0;
            hold_v         <= 1'b0;
            bad            <= 1'b0;
            fin            <= 1'b0;
            crc            <= 32'hFFFFFFFF;
            byte_cnt       <= '0;
            m_axis_tdata   <= '0;
            m_axis_tvalid  <= 1'b0;
            m_axis_tlast   <= 1'b0;
            m_axis_tuser   <= 1'b0;
            frame_good_cnt <= '0;
            frame_bad_cnt  <= '0;
        end else begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            cur_v         <= 1'b0;
            fin           <= 1'b0;
            if (state == IDLE && mii_rx_dv && mii_rxd == 4'h5)
                pcnt <= 4'd1;
            if (state == PREAMBLE && mii_rx_dv && mii_rxd == 4'h5 && pcnt != 4'hF)
                pcnt <= pcnt + 4'd1;
            if (state == PREAMBLE && state_nx == DATA) begin
                crc      <= 32'hFFFFFFFF;
                byte_cnt <= '0;
                have_lo  <= 1'b0;
                hold_v   <= 1'b0;
                bad      <= 1'b0;
            end
            if (state == DATA) begin
                if (mii_rx_dv) begin
                    if (mii_rx_er) bad <= 1'b1;
                    if (have_lo) begin
                        cur   <= {mii_rxd, lo};
                        cur_v <= 1'b1;
                    end else begin
                        lo <= mii_rxd;
                    end
                    have_lo <= !have_lo;
                end else begin
                    if (have_lo) bad <= 1'b1;
                    have_lo <= 1'b0;
                    fin     <= 1'b1;
                end
            end
            if (cur_v) begin
                if (hold_v) begin
                    m_axis_tdata  <= hold;
                    m_axis_tvalid <= 1'b1;
                end
                hold   <= cur;
                hold_v <= 1'b1;
                crc    <= crc_byte(crc, cur);
                if (byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;
            end
            if (fin) begin
                hold_v <= 1'b0;
                if (hold_v) begin
                    m_axis_tdata  <= hold;
                    m_axis_tvalid <= 1'b1;
                    m_axis_tlast  <= 1'b1;
                    m_axis_tuser  <= fin_bad;
                end
                if (fin_bad) begin
                    if (frame_bad_cnt != '1) frame_bad_cnt <= frame_bad_cnt + CNT_WIDTH'(1);
                end else begin
                    if (frame_good_cnt != '1) frame_good_cnt <= frame_good_cnt + CNT_WIDTH'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_mii_rx_deframer.sv
// tb_mii_rx_deframer: randomized and directed frames checked against a frame-level reference model
module tb_mii_rx_deframer;
    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] rxd = '0;
    logic       dv  = 1'b0;
    logic       er  = 1'b0;
    logic [7:0] tdata;
    logic       tvalid, tlast, tuser;
    logic [15:0] good_cnt, bad_cnt;
    logic [7:0] s_tdata;
    logic       s_tvalid, s_tlast, s_tuser;
    logic [1:0] s_good, s_bad;

    int errors = 0;
    int checks = 0;
    int good_m = 0;
    int bad_m  = 0;
    int cyc = 0;
    int last_cyc;
    int mon_lcyc = -1;
    logic [7:0] mon_d[$];
    bit         mon_l[$];
    bit         mon_u[$];

    mii_rx_deframer dut (
        .clk(clk), .rst(rst), .mii_rxd(rxd), .mii_rx_dv(dv), .mii_rx_er(er),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tlast(tlast), .m_axis_tuser(tuser),
        .frame_good_cnt(good_cnt), .frame_bad_cnt(bad_cnt)
    );

    mii_rx_deframer #(.CNT_WIDTH(2)) u_sat (
        .clk(clk), .rst(rst), .mii_rxd(rxd), .mii_rx_dv(dv), .mii_rx_er(er),
        .m_axis_tdata(s_tdata), .m_axis_tvalid(s_tvalid), .m_axis_tlast(s_tlast), .m_axis_tuser(s_tuser),
        .frame_good_cnt(s_good), .frame_bad_cnt(s_bad)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (tvalid) begin
            mon_d.push_back(tdata);
            mon_l.push_back(tlast);
            mon_u.push_back(tuser);
            if (tlast) mon_lcyc = cyc;
        end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fcs_of(input bq_t b);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            c ^= {24'd0, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
        end
        return ~c;
    endfunction

    function automatic bq_t with_fcs(input bq_t p);
        bq_t r = p;
        logic [31:0] f = fcs_of(p);
        r.push_back(f[7:0]);
        r.push_back(f[15:8]);
        r.push_back(f[23:16]);
        r.push_back(f[31:24]);
        return r;
    endfunction

    function automatic bq_t rand_bytes(input int n);
        bq_t r;
        for (int i = 0; i < n; i++) r.push_back(8'($urandom));
        return r;
    endfunction

    task automatic drive(input logic [3:0] d, input logic v, input logic e);
        @(negedge clk);
        rxd = d;
        dv  = v;
        er  = e;
    endtask

    task automatic clear_mon();
        mon_d.delete();
        mon_l.delete();
        mon_u.delete();
        mon_lcyc = -1;
    endtask

    task automatic check_counters(input string tag);
        chk({tag, " good_cnt"}, good_cnt, good_m);
        chk({tag, " bad_cnt"}, bad_cnt, bad_m);
        chk({tag, " sat_good"}, s_good, good_m > 3 ? 3 : good_m);
        chk({tag, " sat_bad"}, s_bad, bad_m > 3 ? 3 : bad_m);
    endtask

    task automatic run_frame(input string tag, input int pre, input logic [3:0] lead,
                             input bq_t b, input bit odd, input int er_idx);
        int  n = b.size();
        bit  accepted, crc_ok, fbad;
        bq_t p;
        int  exp_beats;
        clear_mon();
        drive(lead, 1'b1, 1'b0);
        for (int i = 1; i < pre; i++) drive(4'h5, 1'b1, 1'b0);
        drive(4'hD, 1'b1, 1'b0);
        for (int i = 0; i < n; i++) begin
            drive(b[i][3:0], 1'b1, er_idx == 2 * i);
            drive(b[i][7:4], 1'b1, er_idx == 2 * i + 1);
        end
        if (odd) drive(4'($urandom), 1'b1, 1'b0);
        last_cyc = cyc + 1;
        repeat (6) drive(4'h0, 1'b0, 1'b0);
        accepted = lead == 4'h5 && pre >= 4;
        exp_beats = 0;
        fbad = 1'b1;
        if (accepted) begin
            for (int i = 0; i < n - 4; i++) p.push_back(b[i]);
            crc_ok = n >= 4 && fcs_of(p) == {b[n-1], b[n-2], b[n-3], b[n-4]};
            fbad = !crc_ok || er_idx >= 0 || odd || n < 64;
            exp_beats = n;
            if (fbad) bad_m++;
            else good_m++;
        end
        chk({tag, " beats"}, mon_d.size(), exp_beats);
        if (mon_d.size() == exp_beats && exp_beats > 0) begin
            for (int i = 0; i < n; i++)
                chk($sformatf("%s byte%0d", tag, i), {23'd0, mon_l[i], mon_d[i]}, {23'd0, i == n - 1, b[i]});
            chk({tag, " tuser"}, mon_u[n-1], fbad);
            chk({tag, " latency"}, mon_lcyc - last_cyc, 2);
        end
        check_counters(tag);
    endtask

    initial begin
        bq_t f1, fx, fr;
        int  kind, n, eidx, pre;
        logic [3:0] lead;
        int  tl;

        f1 = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h08, 8'h00};
        for (int i = 0; i < 46; i++) f1.push_back(8'h00);
        f1 = with_fcs(f1);

        #1;
        chk("reset tvalid", tvalid, 0);
        chk("reset tlast", tlast, 0);
        chk("reset tuser", tuser, 0);
        check_counters("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_frame("good", 15, 4'h5, f1, 1'b0, -1);

        fx = f1;
        fx[20] ^= 8'h10;
        run_frame("bitflip", 15, 4'h5, fx, 1'b0, -1);

        run_frame("rx_er", 8, 4'h5, f1, 1'b0, 61);

        run_frame("runt", 8, 4'h5, with_fcs(rand_bytes(16)), 1'b0, -1);

        run_frame("short_pre", 2, 4'h5, f1, 1'b0, -1);
        run_frame("bad_lead", 8, 4'hA, f1, 1'b0, -1);
        run_frame("after_drop", 8, 4'h5, f1, 1'b0, -1);
        run_frame("min_pre", 4, 4'h5, with_fcs(rand_bytes(60)), 1'b0, -1);

        clear_mon();
        drive(4'h5, 1'b1, 1'b0);
        repeat (7) drive(4'h5, 1'b1, 1'b0);
        drive(4'hD, 1'b1, 1'b0);
        for (int i = 0; i < 22; i++) drive(f1[i/2][3:0], 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        dv  = 1'b0;
        #1;
        chk("midrst tvalid", tvalid, 0);
        chk("midrst tlast", tlast, 0);
        good_m = 0;
        bad_m  = 0;
        check_counters("midrst");
        tl = 0;
        foreach (mon_l[i]) tl += mon_l[i];
        chk("midrst no tlast", tl, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_frame("post_rst", 15, 4'h5, f1, 1'b0, -1);
        run_frame("odd_nibble", 15, 4'h5, f1, 1'b1, -1);
        run_frame("zero_bytes", 8, 4'h5, fr, 1'b0, -1);
        run_frame("one_nibble", 8, 4'h5, fr, 1'b1, -1);
        for (int i = 0; i < 4; i++)
            run_frame("good_seq", 8, 4'h5, with_fcs(rand_bytes($urandom_range(60, 80))), 1'b0, -1);

        for (int t = 0; t < 30; t++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: fr = with_fcs(rand_bytes($urandom_range(60, 90)));
                1: fr = with_fcs(rand_bytes($urandom_range(0, 20)));
                2: fr = rand_bytes($urandom_range(0, 5));
                default: begin
                    fr = with_fcs(rand_bytes($urandom_range(60, 70)));
                    n = $urandom_range(0, fr.size() - 1);
                    fr[n] ^= 8'(1 << $urandom_range(0, 7));
                end
            endcase
            n = fr.size();
            eidx = (n > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(0, 2 * n - 1) : -1;
            pre = $urandom_range(1, 18);
            lead = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h5;
            run_frame($sformatf("rnd%0d", t), pre, lead, fr, $urandom_range(0, 5) == 0, eidx);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
